// File: rtl/exc_ctrl_pkg.sv
// Shared types for the exception redirect controller.
// State encoding and the default outstanding-request limit.
package exc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    DRAIN    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam int DEF_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/exc_redirect_ctrl_counter.sv
// Per-channel outstanding bus request counter.
// Saturates at zero when a response arrives with nothing pending.
module outstanding_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             resp,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (req && !resp) begin
      count <= count + ONE;
    end else if (resp && !req && (count != '0)) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Flush, drain and redirect sequencing after a CP0 exception/ERET.
// Fetch gets the new PC only once both bus channels are idle.
module exc_redirect_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_occur,
  input  logic [31:0] exc_pc,
  input  logic        inst_req_fire,
  input  logic        inst_resp_fire,
  input  logic        data_req_fire,
  input  logic        data_resp_fire,
  output logic        flush,
  output logic        inst_req_allow,
  output logic        data_req_allow,
  output logic        inst_resp_discard,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  state_t           state;
  state_t           state_n;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] inst_cnt;
  logic [CNT_W-1:0] data_cnt;
  logic             drained;

  outstanding_counter #(
    .CNT_W(CNT_W)
  ) u_inst_cnt (
    .clk   (clk),
    .reset (reset),
    .req   (inst_req_fire),
    .resp  (inst_resp_fire),
    .count (inst_cnt)
  );

  outstanding_counter #(
    .CNT_W(CNT_W)
  ) u_data_cnt (
    .clk   (clk),
    .reset (reset),
    .req   (data_req_fire),
    .resp  (data_resp_fire),
    .count (data_cnt)
  );

  assign drained = (inst_cnt == '0) && (data_cnt == '0);

  // A new exception while offering the redirect restarts the sequence.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (exc_occur) state_n = FLUSH;
      FLUSH:    state_n = DRAIN;
      DRAIN:    if (drained) state_n = REDIRECT;
      REDIRECT: begin
        if (exc_occur)           state_n = FLUSH;
        else if (redirect_ready) state_n = IDLE;
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_n;
      if (exc_occur) pc_q <= exc_pc;
    end
  end

  assign flush             = (state == FLUSH);
  assign busy              = (state != IDLE);
  assign redirect_valid    = (state == REDIRECT);
  assign redirect_pc       = redirect_valid ? pc_q : 32'h0;
  assign inst_resp_discard = (state == FLUSH) || (state == DRAIN);
  assign inst_req_allow    = (state == IDLE) && (inst_cnt < MAX_CNT);
  assign data_req_allow    = (state == IDLE) && (data_cnt < MAX_CNT);

endmodule
